// File: rtl/l1c_read_arbiter.sv
// rtl/l1c_read_arbiter.sv - round-robin sharing of one AXI4 read port between L1 I- and D-cache
module l1c_read_arbiter #(
  parameter int          LINE_BEATS = 4,
  parameter logic [3:0]  ID_I       = 4'd0,
  parameter logic [3:0]  ID_D       = 4'd1,
  parameter logic [15:0] UNCACHE_HI = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic        i_wait,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_rvalid,
  output logic        d_wait,
  output logic [31:0] rdata,
  output logic [1:0]  beat,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  localparam logic       G_I      = 1'b0;
  localparam logic       G_D      = 1'b1;
  localparam logic [3:0] LEN_LINE = 4'(LINE_BEATS - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pick;
  logic        hit;
  logic        done;
  logic [3:0]  cur_id;

  // Response status is not acted on; data is forwarded regardless.
  logic unused_rresp;
  assign unused_rresp = ^RRESP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= G_I;
      last_grant_q <= G_D;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
    end
  end

  assign cur_id = (grant_q == G_D) ? ID_D : ID_I;
  assign hit    = (state_q == S_DATA) && RVALID && (RID == cur_id);
  assign done   = hit && RLAST;
  // On a tie the requester that did not win last time goes first.
  assign pick   = (i_req && d_req) ? ~last_grant_q : ~i_req;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d = pick;
          state_d = S_ADDR;
          if (pick == G_D) begin
            addr_d = d_addr;
            len_d  = (d_addr[31:16] == UNCACHE_HI) ? 4'd0 : LEN_LINE;
          end else begin
            addr_d = i_addr;
            len_d  = LEN_LINE;
          end
        end
      end
      S_ADDR: begin
        if (ARREADY) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (hit) begin
          cnt_d = cnt_q + 2'd1;
          if (RLAST) begin
            state_d      = S_IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ARVALID  = (state_q == S_ADDR);
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARID     = cur_id;
  assign ARSIZE   = 3'b010;
  assign ARBURST  = 2'b01;
  assign RREADY   = (state_q == S_DATA);
  assign rdata    = RDATA;
  assign beat     = cnt_q;
  assign i_rvalid = hit && (grant_q == G_I);
  assign d_rvalid = hit && (grant_q == G_D);
  assign i_wait   = i_req && !(done && (grant_q == G_I));
  assign d_wait   = d_req && !(done && (grant_q == G_D));

endmodule
